endian_swap_stream: RTL
=======================

# endian_swap_stream

Streaming, parametrised byte-order converter, successor to the fixed 32-bit little-to-big-endian swap. It accepts words on a valid/ready interface and reorders bytes under a per-beat runtime mode (none, halfword, word, full-width). Output is registered behind a 2-entry skid buffer, so neither direction has a combinational ready/valid path. It sits between bus-side ingress logic and little-endian datapath consumers.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 4*BYTE and at least 4*BYTE
- BYTE, 8, byte width in bits
- CNT_W, 16, width of the beat counter (present only under ENDIAN_SWAP_STATS_EN)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  block can accept a beat
- mode_i  input  2  swap mode, sampled with the accepted beat
- le_data_i  input  DATA_W  input data
- out_valid_o  output  1  output beat valid
- out_ready_i  input  1  downstream accepts the beat
- be_data_o  output  DATA_W  converted data
- mode_o  output  2  mode the output beat was converted with
- beat_cnt_o  output  CNT_W  saturating count of output handshakes (stats build only)

## Operation
- Modes, applied independently to every aligned group. Byte index 0 is the LSB.
  - 0 PASS: data is unchanged.
  - 1 HALF: swap the two bytes within each 16-bit group.
  - 2 WORD: reverse the 4 bytes within each 32-bit group.
  - 3 FULL: reverse all DATA_W/BYTE bytes.
- When DATA_W = 32, WORD and FULL are identical.
- Conversion is combinational on input. Data and mode are stored post-conversion.
- Storage is a main output register (M) plus a skid register (S).
- Input accept: in_valid_i && in_ready_o.
- Output handshake: out_valid_o && out_ready_i.
- On accept:
  - If M is empty, or M is handshaking this cycle, the beat loads M.
  - Otherwise the beat loads S.
- When M handshakes and S is full, S moves into M and S empties.
- in_ready_o = !S_full. It is registered, so it is not a function of out_ready_i.
- Beats never reorder, duplicate or drop. Data and mode in M stay stable while out_valid_o && !out_ready_i.
- Reset can arrive mid-operation. Both entries are discarded immediately (asynchronous), and in-flight beats are lost.

## Timing
- Latency: a beat accepted at edge N is presented on out_valid_o/be_data_o after edge N (1 cycle) when M is free.
- Throughput: 1 beat per cycle while out_ready_i stays high.
- Downstream stall:
  - The first stalled beat occupies M.
  - The next accepted beat occupies S.
  - in_ready_o drops after the edge at which S fills.
- Simultaneous accept and output handshake with S empty: the new beat goes to M, and occupancy is unchanged.
- Simultaneous accept and output handshake with S full cannot occur, because in_ready_o = 0.
- Reset values:
  - out_valid_o = 0, be_data_o = 0, mode_o = 0
  - in_ready_o = 1 (asserted both during and after reset)
  - beat_cnt_o = 0
- in_valid_i during reset is ignored.

## Configuration
- ENDIAN_SWAP_STATS_EN defined:
  - beat_cnt_o increments by 1 on each output handshake.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It clears only on reset.
- Not defined:
  - The counter logic is absent.
  - beat_cnt_o is driven constant 0, so the port list is unchanged.

## Structure
- Shared package endian_pkg holds:
  - typedef enum logic [1:0] endian_mode_e {PASS, HALF, WORD, FULL}
  - the BYTE default constant
- Natural sub-module endian_swap_comb:
  - purely combinational, parametrised by DATA_W/BYTE
  - input data + endian_mode_e, output swapped data
  - reusable by other datapath blocks

## Test plan
- DATA_W=32, mode FULL, le_data_i=0x11223344, out_ready_i=1 -> be_data_o=0x44332211 one cycle later, mode_o=FULL.
- DATA_W=64, data 0x0102030405060708:
  - HALF -> 0x0201040306050807
  - WORD -> 0x0403020108070605
  - FULL -> 0x0807060504030201
  - PASS -> unchanged
  - Send back-to-back with 4 consecutive outputs.
- Stall: hold out_ready_i=0 and offer 3 beats A,B,C.
  - A and B are accepted; in_ready_o=0 after B; C is held.
  - Release out_ready_i -> A, B, C emerge in order with no gaps after A.
  - A stays stable on be_data_o throughout the stall.
- Random valid/ready toggling for 1000 beats with a scoreboard -> no loss, duplication or reordering, and out_valid_o never drops without a handshake.
- Assert reset with M and S both full -> out_valid_o=0 and in_ready_o=1 immediately; the next beat after release appears alone.
- Stats build: 5 output handshakes -> beat_cnt_o=5.
- Stats build with CNT_W=3: 10 handshakes -> beat_cnt_o=7.
- Without macro: beat_cnt_o stays 0.

Source files
------------

// File: rtl/endian_pkg.sv
// -----------------------------------------------------------------------------
// endian_pkg
// Shared definitions for the byte-order conversion blocks.
//   BYTE_DEFAULT  : default byte width in bits
//   endian_mode_e : per-beat swap mode (PASS, HALF, WORD, FULL)
// -----------------------------------------------------------------------------
package endian_pkg;

  localparam int BYTE_DEFAULT = 8;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    FULL = 2'd3
  } endian_mode_e;

endpackage

// File: rtl/endian_swap_comb.sv
// -----------------------------------------------------------------------------
// endian_swap_comb
// Purely combinational byte reorder. Every output byte is selected from one
// input byte according to the mode; the byte at index 0 is the LSB.
// Ports:
//   data_i : input data, DATA_W bits
//   mode_i : swap mode (endian_mode_e)
//   data_o : reordered data, DATA_W bits
// DATA_W must be a multiple of 4*BYTE and at least 4*BYTE.
// -----------------------------------------------------------------------------
module endian_swap_comb
  import endian_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE   = BYTE_DEFAULT
) (
  input  logic [DATA_W-1:0] data_i,
  input  endian_mode_e      mode_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int NB = DATA_W / BYTE;

  // Each output byte picks its source byte. Flipping bit 0 of the byte index
  // swaps within an aligned 16-bit group; flipping bits 1:0 reverses within
  // an aligned 32-bit group; NB-1-g reverses across the full width.
  for (genvar g = 0; g < NB; g++) begin : g_byte
    localparam int HS = g ^ 1;
    localparam int WS = g ^ 3;
    localparam int FS = NB - 1 - g;

    assign data_o[g*BYTE +: BYTE] =
      (mode_i == HALF) ? data_i[HS*BYTE +: BYTE] :
      (mode_i == WORD) ? data_i[WS*BYTE +: BYTE] :
      (mode_i == FULL) ? data_i[FS*BYTE +: BYTE] :
                         data_i[g*BYTE +: BYTE];
  end

endmodule

// File: rtl/endian_swap_stream.sv
// -----------------------------------------------------------------------------
// endian_swap_stream
// Streaming byte-order converter with valid/ready on both sides. Data is
// converted combinationally on input and stored post-conversion in a main
// output register (M) backed by a skid register (S), so neither in_ready_o nor
// out_valid_o depends combinationally on the opposite side.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   in_valid_i   : input beat valid
//   in_ready_o   : block can accept a beat (registered, = skid empty)
//   mode_i       : swap mode sampled with the accepted beat
//   le_data_i    : input data
//   out_valid_o  : output beat valid
//   out_ready_i  : downstream accepts the beat
//   be_data_o    : converted data
//   mode_o       : mode the output beat was converted with
//   beat_cnt_o   : saturating output handshake count
// Configuration macro: ENDIAN_SWAP_STATS_EN enables the beat counter; without
// it beat_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module endian_swap_stream
  import endian_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE   = BYTE_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] le_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] be_data_o,
  output logic [1:0]        mode_o,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  endian_mode_e      inMode;
  logic [DATA_W-1:0] swapData;
  logic              accept;
  logic              outHs;

  logic              mValid_q, mValid_d;
  logic              sValid_q, sValid_d;
  logic [DATA_W-1:0] mData_q,  mData_d;
  logic [DATA_W-1:0] sData_q,  sData_d;
  endian_mode_e      mMode_q,  mMode_d;
  endian_mode_e      sMode_q,  sMode_d;

  assign inMode = endian_mode_e'(mode_i);

  endian_swap_comb #(
    .DATA_W (DATA_W),
    .BYTE   (BYTE)
  ) u_swap (
    .data_i (le_data_i),
    .mode_i (inMode),
    .data_o (swapData)
  );

  // Accepting only while the skid is empty guarantees there is always room
  // for the beat, whatever downstream does on the same edge.
  assign accept = in_valid_i && !sValid_q;
  assign outHs  = mValid_q && out_ready_i;

  // Occupancy update. When M drains, the skid (older) has priority over a new
  // beat; both cannot be present together because accept needs S empty.
  always_comb begin
    mValid_d = mValid_q;
    sValid_d = sValid_q;
    mData_d  = mData_q;
    sData_d  = sData_q;
    mMode_d  = mMode_q;
    sMode_d  = sMode_q;
    if (outHs) begin
      if (sValid_q) begin
        mData_d  = sData_q;
        mMode_d  = sMode_q;
        sValid_d = 1'b0;
      end else if (accept) begin
        mData_d = swapData;
        mMode_d = inMode;
      end else begin
        mValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!mValid_q) begin
        mValid_d = 1'b1;
        mData_d  = swapData;
        mMode_d  = inMode;
      end else begin
        sValid_d = 1'b1;
        sData_d  = swapData;
        sMode_d  = inMode;
      end
    end
  end

  // Storage registers; reset discards both entries immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mValid_q <= 1'b0;
      sValid_q <= 1'b0;
      mData_q  <= '0;
      sData_q  <= '0;
      mMode_q  <= PASS;
      sMode_q  <= PASS;
    end else begin
      mValid_q <= mValid_d;
      sValid_q <= sValid_d;
      mData_q  <= mData_d;
      sData_q  <= sData_d;
      mMode_q  <= mMode_d;
      sMode_q  <= sMode_d;
    end
  end

  assign in_ready_o  = !sValid_q;
  assign out_valid_o = mValid_q;
  assign be_data_o   = mData_q;
  assign mode_o      = mMode_q;

`ifdef ENDIAN_SWAP_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating handshake counter: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (outHs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt_o = cnt_q;
`else
  assign beat_cnt_o = '0;
`endif

endmodule
